// File: rtl/calc_pkg.sv
// Shared op/state codes and width helper for the calculator core.
// Imported by calc_seq_unit and calc_core_param.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HAVE_X = 3'd1,
    ST_HAVE_Y = 3'd2,
    ST_READY  = 3'd3,
    ST_EXEC   = 3'd4
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/calc_seq_unit.sv
// Iterative WIDTH-step shift-add multiplier / restoring divider.
// Ports: clk, rst (sync, active-low), start loads a/b and mode
// (0 = multiply, 1 = divide); done flags the final step, whose
// combinational lo (product low / quotient) and hi (product high /
// remainder) are to be captured on that same edge.
module calc_seq_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic             run;
  logic             md;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hr;
  logic [WIDTH-1:0] lr;
  logic [WIDTH-1:0] bm;
  logic [WIDTH-1:0] hn;
  logic [WIDTH-1:0] ln;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   dif;
  logic             ge;

  // One iteration of either algorithm; hr/lr hold the
  // partial product or remainder/quotient pair.
  always_comb begin
    hn  = hr;
    ln  = lr;
    sum = '0;
    sh  = '0;
    dif = '0;
    ge  = 1'b0;
    if (!md) begin
      sum = {1'b0, hr}
          + ({(WIDTH+1){lr[0]}} & {1'b0, bm});
      {hn, ln} = {sum, lr[WIDTH-1:1]};
    end else begin
      sh  = {hr, lr[WIDTH-1]};
      ge  = (sh >= {1'b0, bm});
      dif = sh - {1'b0, bm};
      hn  = ge ? dif[WIDTH-1:0] : sh[WIDTH-1:0];
      ln  = {lr[WIDTH-2:0], ge};
    end
  end

  assign done = run && (cnt == CNT_W'(WIDTH - 1));
  assign lo   = ln;
  assign hi   = hn;

  always_ff @(posedge clk) begin
    if (!rst) begin
      run <= 1'b0;
      md  <= 1'b0;
      cnt <= '0;
      hr  <= '0;
      lr  <= '0;
      bm  <= '0;
    end else if (start) begin
      run <= 1'b1;
      md  <= mode;
      cnt <= '0;
      hr  <= '0;
      lr  <= a;
      bm  <= b;
    end else if (run) begin
      hr <= hn;
      lr <= ln;
      if (done) run <= 1'b0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/calc_core_param.sv
// Calculator core: operand capture FSM, single-cycle ALU, seq unit.
// Ports: clk, rst (sync active-low), load_x/load_y/key capture,
// start/op execute; busy, done, err, state, result report.
// Define CALC_MOD_EN to enable op 100 (MOD); else it is illegal.
module calc_core_param
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_x,
  input  logic             load_y,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] key,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] result
);

  state_t           cur;
  state_t           nxt;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             xv;
  logic             yv;
  logic [2:0]       opq;
  logic             accept;
  logic             ld_ok;
  logic             nxv;
  logic             nyv;
  logic             seq_op;
  logic             seq_start;
  logic             seq_done;
  logic [WIDTH-1:0] seq_lo;
  logic [WIDTH-1:0] seq_hi;
  logic             fast;
  logic             finish;
  logic [WIDTH-1:0] res_n;
  logic             err_n;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             y_zero;

  assign y_zero = (y == '0);
  assign accept = start && (cur == ST_READY);
  // start wins over a same-cycle load
  assign ld_ok  = (cur != ST_EXEC) && !accept;
  assign nxv    = xv | (ld_ok & load_x);
  assign nyv    = yv | (ld_ok & load_y);

`ifdef CALC_MOD_EN
  assign seq_op = (op == OP_MUL)
               || (((op == OP_DIV) || (op == OP_MOD)) && !y_zero);
`else
  assign seq_op = (op == OP_MUL)
               || ((op == OP_DIV) && !y_zero);
`endif
  assign seq_start = accept && seq_op;

  calc_seq_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (seq_start),
    .mode  (op != OP_MUL),
    .a     (x),
    .b     (y),
    .done  (seq_done),
    .lo    (seq_lo),
    .hi    (seq_hi)
  );

  always_comb begin
    res_n = result;
    err_n = err;
    fast  = 1'b1;
    sum   = {1'b0, x} + {1'b0, y};
    dif   = {1'b0, x} - {1'b0, y};
    unique case (1'b1)
      (opq == OP_ADD): begin
        res_n = sum[WIDTH-1:0];
        err_n = sum[WIDTH];
      end
      (opq == OP_SUB): begin
        res_n = dif[WIDTH-1:0];
        err_n = dif[WIDTH];
      end
      (opq == OP_MUL): begin
        fast  = 1'b0;
        res_n = seq_lo;
        err_n = |seq_hi;
      end
      (opq == OP_DIV): begin
        if (y_zero) begin
          res_n = '1;
          err_n = 1'b1;
        end else begin
          fast  = 1'b0;
          res_n = seq_lo;
          err_n = 1'b0;
        end
      end
      (opq == OP_MOD): begin
`ifdef CALC_MOD_EN
        if (y_zero) begin
          res_n = '1;
          err_n = 1'b1;
        end else begin
          fast  = 1'b0;
          res_n = seq_hi;
          err_n = 1'b0;
        end
`else
        err_n = 1'b1;
`endif
      end
      (opq == OP_AND): begin
        res_n = x & y;
        err_n = 1'b0;
      end
      (opq == OP_OR): begin
        res_n = x | y;
        err_n = 1'b0;
      end
      (opq == OP_XOR): begin
        res_n = x ^ y;
        err_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign finish = (cur == ST_EXEC) && (fast || seq_done);

  always_comb begin
    nxt = cur;
    if (cur == ST_EXEC) begin
      if (finish) nxt = ST_READY;
    end else if (accept) begin
      nxt = ST_EXEC;
    end else begin
      unique case (1'b1)
        (nxv && nyv): nxt = ST_READY;
        (nxv && !nyv): nxt = ST_HAVE_X;
        (!nxv && nyv): nxt = ST_HAVE_Y;
        default:       nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur    <= ST_IDLE;
      x      <= '0;
      y      <= '0;
      xv     <= 1'b0;
      yv     <= 1'b0;
      opq    <= OP_ADD;
      result <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      cur  <= nxt;
      done <= finish;
      xv   <= nxv;
      yv   <= nyv;
      if (ld_ok && load_x) x <= key;
      if (ld_ok && load_y) y <= key;
      if (accept) opq <= op;
      if (finish) begin
        result <= res_n;
        err    <= err_n;
      end
    end
  end

  assign busy  = (cur == ST_EXEC);
  assign state = cur;

endmodule

// File: tb/tb_calc_core_param.sv
// Self-checking bench for calc_core_param (WIDTH=8): directed
// scenarios plus randomized ops against an arithmetic model.
module tb_calc_core_param;

  localparam int W = 8;
  localparam int M = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_x = 1'b0;
  logic         load_y = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] key = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic [2:0]   state;
  logic [W-1:0] result;

  calc_core_param #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .load_x (load_x),
    .load_y (load_y),
    .start  (start),
    .op     (op),
    .key    (key),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .state  (state),
    .result (result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int mx, my, mres;
  bit vx, vy, merr;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mstate();
    if (vx && vy) return 3;
    if (vx) return 1;
    if (vy) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; vx = 0; vy = 0; mres = 0; merr = 0;
  endtask

  task automatic model_op(input int o, output int r,
                          output bit e, output int lat);
    int p;
    r = 0; e = 0; lat = 1;
    case (o)
      0: begin p = mx + my; r = p & M; e = (p > M); end
      1: begin r = (mx - my) & M; e = (mx < my); end
      2: begin p = mx * my; r = p & M; e = (p > M); lat = W; end
      3: begin
        if (my == 0) begin r = M; e = 1; end
        else begin r = mx / my; lat = W; end
      end
      4: begin
`ifdef CALC_MOD_EN
        if (my == 0) begin r = M; e = 1; end
        else begin r = mx % my; lat = W; end
`else
        r = mres; e = 1;
`endif
      end
      5: r = mx & my;
      6: r = mx | my;
      default: r = mx ^ my;
    endcase
  endtask

  task automatic do_load(input bit lx, input bit ly, input int k);
    load_x = lx;
    load_y = ly;
    key = k[W-1:0];
    tick();
    load_x = 0;
    load_y = 0;
    if (lx) begin mx = k; vx = 1; end
    if (ly) begin my = k; vy = 1; end
    check("state_ld", state, mstate());
  endtask

  // mode 1: load_x pulse mid-EXEC; mode 2: load_x with start
  task automatic run_op(input int o, input int mode);
    int r, lat, n;
    bit e;
    model_op(o, r, e, lat);
    op = o[2:0];
    start = 1;
    if (mode == 2) begin load_x = 1; key = 8'h5A; end
    tick();
    start = 0;
    load_x = 0;
    check("busy_k", busy, 1);
    check("state_k", state, 4);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n > 0) check("busy_run", busy, 1);
      if (mode == 1 && n == 2) begin load_x = 1; key = 8'h11; end
      tick();
      load_x = 0;
      n++;
    end
    check("latency", n, lat);
    check("result", result, r);
    check("err", err, e);
    check("state_done", state, 3);
    check("busy_done", busy, 0);
    tick();
    check("done_pulse", done, 0);
    mres = r;
    merr = e;
  endtask

  initial begin
    int k, sel, o, seen;
    model_reset();
    tick();
    tick();
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state, 0);
    rst = 1;
    tick();

    op = 0; start = 1;
    tick();
    start = 0;
    check("start_idle_st", state, 0);
    check("start_idle_done", done, 0);

    do_load(1, 0, 8'h84);
    do_load(0, 1, 8'h44);
    run_op(0, 0);
    do_load(1, 0, 8'h44);
    do_load(0, 1, 8'h84);
    run_op(1, 0);
    do_load(1, 0, 8'h84);
    do_load(0, 1, 8'h44);
    run_op(2, 1);
    check("x_kept", mx, 8'h84);
    run_op(0, 0);
    run_op(3, 0);
    run_op(4, 0);
    run_op(5, 2);
    do_load(0, 1, 8'h00);
    run_op(3, 0);
    run_op(4, 0);

    do_load(0, 1, 8'h44);
    op = 2; start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    rst = 0;
    tick();
    model_reset();
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_err", err, 0);
    check("abort_state", state, 0);
    check("abort_busy", busy, 0);
    rst = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) seen = 1;
    end
    check("abort_no_done", seen, 0);
    do_load(1, 1, 8'h37);
    run_op(0, 0);

    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 3);
      k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, M);
      if (sel == 1) do_load(1, 0, k);
      if (sel == 2) do_load(0, 1, k);
      if (sel == 3) do_load(1, 1, k);
      o = $urandom_range(0, 7);
      run_op(o, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
Parametrised successor to the fixed 8-bit keypad calculator core. Captures two unsigned operands (X, Y) and an operation code through separate load strobes, then executes on start. Single-cycle ALU ops; iterative shift-add multiply and restoring divide. Reports result, done pulse, error flag and FSM state to the display/control layer.

Parameters:
WIDTH, 8, operand/result width in bits (>=4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
load_x  in  1  capture key into X
load_y  in  1  capture key into Y
start  in  1  execute op on held X, Y
op  in  3  operation code, sampled with start
key  in  WIDTH  operand data bus
busy  out  1  high while in EXEC
done  out  1  one-cycle pulse when result/err update
err  out  1  error/overflow flag for last result
state  out  3  FSM state code
result  out  WIDTH  last result, held until next done

Behaviour:
- Reset (rst==0 at edge): X=Y=0, valid flags clear, state=IDLE, busy=0, done=0, err=0, result=0. Reset mid-EXEC aborts the op with no done pulse.
- States/codes: IDLE=0 (no operands), HAVE_X=1, HAVE_Y=2, READY=3 (both valid), EXEC=4.
- Loads accepted only outside EXEC; ignored while busy. load_x and load_y in the same cycle both capture key. A reload overwrites the value; valid flags stay set.
- start accepted only in READY; ignored elsewhere (no done, no err change). op is latched at acceptance.
- Op codes: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD (optional), 101 AND, 110 OR, 111 XOR.
- Latency, with start sampled at edge k: ADD/SUB/AND/OR/XOR -> result/err/done registered at edge k+1. MUL/DIV/MOD -> edge k+WIDTH. DIV/MOD with Y==0 -> edge k+1.
- done is high exactly one cycle. busy is high from edge k to the done edge. After done, state returns to READY with X and Y retained, so consecutive ops need no reload.
- Arithmetic: unsigned. Result is the low WIDTH bits.
  - ADD: err=carry out.
  - SUB: err=borrow (X<Y); result wraps.
  - MUL: err=1 if upper WIDTH bits of the 2*WIDTH product are nonzero.
  - DIV: quotient.
  - Y==0 for DIV/MOD: result=all ones, err=1.
  - Logic ops: err=0.
- Illegal op (100 with the feature compiled out): done at k+1, result unchanged, err=1.
- start arriving in the same cycle as a load in READY: start wins; the load is ignored.

Optional Feature:
CALC_MOD_EN
- Defined: op 100 = MOD, the remainder of restoring division, same latency as DIV; Y==0 gives all ones, err=1.
- Undefined: no remainder path is kept; op 100 is illegal as described above.

Decomposition:
- Package calc_pkg:
  - op code localparams (OP_ADD..OP_XOR);
  - state code localparams (ST_IDLE..ST_EXEC);
  - width helper function for CNT_W.
- Sub-module calc_seq_unit:
  - iterative WIDTH-cycle shift-add multiplier / restoring divider;
  - ports: start, mode, a, b, done, lo, hi/rem.
- Top holds the FSM, operand registers and single-cycle ALU.

Test Plan (WIDTH=8):
- Reset, load_x key=0x84, load_y key=0x44, ADD -> result=0xC8, err=0, done one cycle after start edge; state 0->1->3->4->3.
- Same operands, SUB with X=0x44, Y=0x84 -> result=0xC0, err=1.
- X=0x84, Y=0x44, MUL -> done exactly 8 cycles after start, result=0x10, err=1 (product 0x2310); busy high for those 8 cycles.
- X=0x84, Y=0x44, DIV -> result=0x01, err=0. With CALC_MOD_EN, op 100 -> 0x40; without it, op 100 -> err=1 and result unchanged.
- Y=0x00, DIV -> result=0xFF, err=1, done at start+1. start in IDLE, and load_x during EXEC -> both ignored; X is unchanged after done.
- Pull rst low at cycle 4 of a MUL -> no done pulse, all outputs zero, state=IDLE next cycle; a fresh load/ADD then completes correctly.
